pipe_ctrl_irq: RTL and testbench

PIPE_CTRL_IRQ -- requirements
Module: pipe_ctrl_irq

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/pipe_ctrl_irq.sv | 182 ++++++++++++++++++
 tb/tb_pipe_ctrl_irq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline interrupt controller.
// FSM encoding, vector stride and cause width.
package pipe_ctrl_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] StRun    = 2'd0;
  localparam logic [StateW-1:0] StDrain  = 2'd1;
  localparam logic [StateW-1:0] StVector = 2'd2;

  // Byte distance between consecutive interrupt vectors.
  localparam int unsigned VecStride = 4;

  // Width of the cause field (index of the accepted line).
  localparam int unsigned CauseW = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the request vector wins.
module irq_prio_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [CauseW-1:0]  o_idx
);

  // Scan from the top down so the lowest pending index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = CauseW'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_irq.sv
// Pipeline control with interrupt entry/exit for a 5-stage pipe.
// Accepts a masked level IRQ, drains EXE/MEM/WB, redirects to the vector,
// and returns on ERET. Optional single-step debug under DEBUG_STEP_EN.
module pipe_ctrl_irq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned           NUM_IRQ      = 4,
  parameter int unsigned           ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]     VEC_BASE     = ADDR_W'(32'h0000_0100),
  parameter int unsigned           DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               id_valid,
  input  logic [ADDR_W-1:0]  pc_id,
  input  logic               load_use,
  input  logic               eret_id,
`ifdef DEBUG_STEP_EN
  input  logic               debug_en,
  input  logic               debug_step,
`endif
  output logic               if_rst,
  output logic               if_en,
  output logic               id_rst,
  output logic               id_en,
  output logic               exe_rst,
  output logic               exe_en,
  output logic               mem_rst,
  output logic               mem_en,
  output logic               wb_rst,
  output logic               wb_en,
  output logic               pc_redirect,
  output logic [ADDR_W-1:0]  pc_redirect_addr,
  output logic [ADDR_W-1:0]  epc,
  output logic [CauseW-1:0]  cause,
  output logic               in_isr
);

  localparam logic [2:0] DrainLast = 3'(DRAIN_CYCLES - 1);

  logic [StateW-1:0] r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_epc;
  logic [CauseW-1:0] r_cause;
  logic              r_in_isr;

  logic              w_irq_valid;
  logic [CauseW-1:0] w_irq_idx;
  logic              w_accept;
  logic              w_eret;
  logic              w_adv;
  logic [ADDR_W-1:0] w_vec_addr;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .i_req   (irq & irq_mask),
    .o_valid (w_irq_valid),
    .o_idx   (w_irq_idx)
  );

`ifdef DEBUG_STEP_EN
  logic r_debug_step_prev;

  // Remember last step level to detect its rising edge.
  always_ff @(posedge clk) begin
    if (rst) r_debug_step_prev <= 1'b0;
    else     r_debug_step_prev <= debug_step;
  end

  assign w_adv = !debug_en || (debug_step && !r_debug_step_prev);
`else
  assign w_adv = 1'b1;
`endif

  assign w_accept   = (r_state == StRun) && !r_in_isr && id_valid && w_irq_valid;
  assign w_eret     = (r_state == StRun) && r_in_isr && eret_id && id_valid && !load_use;
  // Sum wraps naturally at ADDR_W bits.
  assign w_vec_addr = VEC_BASE + (ADDR_W'(r_cause) * ADDR_W'(VecStride));

  // Stage enables/resets and PC redirect decoded from state and hazards.
  always_comb begin
    if_en            = 1'b1;
    id_en            = 1'b1;
    exe_en           = 1'b1;
    mem_en           = 1'b1;
    wb_en            = 1'b1;
    if_rst           = 1'b0;
    id_rst           = 1'b0;
    exe_rst          = 1'b0;
    mem_rst          = 1'b0;
    wb_rst           = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    if (rst) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (!w_adv) begin
      // Debug suspend: whole pipe holds, no redirect while frozen.
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_accept) begin
            // Accept beats load-use: squash ID instead of stalling it.
            id_rst = 1'b1;
            if_en  = 1'b0;
          end else if (w_eret) begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = r_epc;
            id_rst           = 1'b1;
          end else if (load_use) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
          end
        end
        StDrain: begin
          if_en  = 1'b0;
          id_rst = 1'b1;
        end
        StVector: begin
          pc_redirect      = 1'b1;
          pc_redirect_addr = w_vec_addr;
          id_rst           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM, drain counter and saved interrupt context.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StRun;
      r_cnt    <= '0;
      r_epc    <= '0;
      r_cause  <= '0;
      r_in_isr <= 1'b0;
    end else if (w_adv) begin
      case (r_state)
        StRun: begin
          if (w_accept) begin
            r_epc   <= pc_id;
            r_cause <= w_irq_idx;
            r_cnt   <= '0;
            r_state <= StDrain;
          end else if (w_eret) begin
            r_in_isr <= 1'b0;
          end
        end
        StDrain: begin
          if (r_cnt == DrainLast) begin
            r_cnt   <= '0;
            r_state <= StVector;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StVector: begin
          r_in_isr <= 1'b1;
          r_state  <= StRun;
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign epc    = r_epc;
  assign cause  = r_cause;
  assign in_isr = r_in_isr;

endmodule

// File: tb/tb_pipe_ctrl_irq.sv
// Directed bench for pipe_ctrl_irq at default parameters.
// Define DEBUG_STEP_EN on both RTL and bench to exercise single-step.
module tb_pipe_ctrl_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        id_valid;
  logic [31:0] pc_id;
  logic        load_use;
  logic        eret_id;
`ifdef DEBUG_STEP_EN
  logic        debug_en;
  logic        debug_step;
`endif
  logic        if_rst, if_en, id_rst, id_en, exe_rst, exe_en;
  logic        mem_rst, mem_en, wb_rst, wb_en;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic [31:0] epc;
  logic [2:0]  cause;
  logic        in_isr;

  logic [4:0]  rsts;
  logic [4:0]  ens;
  assign rsts = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
  assign ens  = {if_en, id_en, exe_en, mem_en, wb_en};

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_irq dut (
    .clk              (clk),
    .rst              (rst),
    .irq              (irq),
    .irq_mask         (irq_mask),
    .id_valid         (id_valid),
    .pc_id            (pc_id),
    .load_use         (load_use),
    .eret_id          (eret_id),
`ifdef DEBUG_STEP_EN
    .debug_en         (debug_en),
    .debug_step       (debug_step),
`endif
    .if_rst           (if_rst),
    .if_en            (if_en),
    .id_rst           (id_rst),
    .id_en            (id_en),
    .exe_rst          (exe_rst),
    .exe_en           (exe_en),
    .mem_rst          (mem_rst),
    .mem_en           (mem_en),
    .wb_rst           (wb_rst),
    .wb_en            (wb_en),
    .pc_redirect      (pc_redirect),
    .pc_redirect_addr (pc_redirect_addr),
    .epc              (epc),
    .cause            (cause),
    .in_isr           (in_isr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1ns after the edge so registers have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    irq      = '0;
    irq_mask = '0;
    id_valid = 1'b0;
    pc_id    = '0;
    load_use = 1'b0;
    eret_id  = 1'b0;
`ifdef DEBUG_STEP_EN
    debug_en   = 1'b0;
    debug_step = 1'b0;
`endif
    tick();
    tick();
    check_val("rst_rsts", 32'(rsts), 32'h1f);
    check_val("rst_ens", 32'(ens), 32'h1f);
    check_val("rst_redir", 32'(pc_redirect), 32'h0);

    rst = 1'b0;
    settle();
    check_val("post_rst_epc", epc, 32'h0);
    check_val("post_rst_cause", 32'(cause), 32'h0);
    check_val("post_rst_isr", 32'(in_isr), 32'h0);
    check_val("post_rst_rsts", 32'(rsts), 32'h0);
    check_val("post_rst_ens", 32'(ens), 32'h1f);

    // Masked-off line: no accept.
    irq      = 4'b1000;
    irq_mask = 4'b0111;
    id_valid = 1'b1;
    pc_id    = 32'h40;
    settle();
    check_val("masked_rsts", 32'(rsts), 32'h0);
    check_val("masked_ens", 32'(ens), 32'h1f);
    tick();
    check_val("masked_isr", 32'(in_isr), 32'h0);

    // Pending but ID empty: no accept.
    irq      = 4'b0110;
    irq_mask = 4'b1111;
    id_valid = 1'b0;
    settle();
    check_val("novalid_rsts", 32'(rsts), 32'h0);
    tick();
    check_val("novalid_epc", epc, 32'h0);

    // Accept cycle: lines 1 and 2 pending, line 1 wins.
    id_valid = 1'b1;
    settle();
    check_val("acc_rsts", 32'(rsts), 32'h08);
    check_val("acc_ens", 32'(ens), 32'h0f);
    check_val("acc_redir", 32'(pc_redirect), 32'h0);
    tick();
    irq = '0;
    settle();
    check_val("acc_epc", epc, 32'h40);
    check_val("acc_cause", 32'(cause), 32'h1);
    for (int k = 0; k < 3; k++) begin
      check_val("drain_redir", 32'(pc_redirect), 32'h0);
      check_val("drain_rsts", 32'(rsts), 32'h08);
      check_val("drain_ens", 32'(ens), 32'h0f);
      tick();
    end
    check_val("vec_redir", 32'(pc_redirect), 32'h1);
    check_val("vec_addr", pc_redirect_addr, 32'h104);
    check_val("vec_idrst", 32'(id_rst), 32'h1);
    check_val("vec_isr_pre", 32'(in_isr), 32'h0);
    tick();
    check_val("isr_set", 32'(in_isr), 32'h1);
    check_val("isr_redir_off", 32'(pc_redirect), 32'h0);

    // No nesting.
    irq   = 4'b0001;
    pc_id = 32'h200;
    settle();
    check_val("nest_rsts", 32'(rsts), 32'h0);
    tick();
    check_val("nest_cause", 32'(cause), 32'h1);
    check_val("nest_epc", epc, 32'h40);

    // ERET returns to saved PC in the same cycle.
    irq     = '0;
    eret_id = 1'b1;
    settle();
    check_val("eret_redir", 32'(pc_redirect), 32'h1);
    check_val("eret_addr", pc_redirect_addr, 32'h40);
    check_val("eret_idrst", 32'(id_rst), 32'h1);
    tick();
    check_val("eret_isr_clr", 32'(in_isr), 32'h0);

    // ERET outside the handler is ignored.
    settle();
    check_val("eret_noisr", 32'(pc_redirect), 32'h0);
    eret_id = 1'b0;

    // Load-use bubble.
    load_use = 1'b1;
    settle();
    check_val("lu_ens", 32'(ens), 32'h07);
    check_val("lu_rsts", 32'(rsts), 32'h04);
    tick();
    load_use = 1'b0;
    settle();
    check_val("lu_clear_ens", 32'(ens), 32'h1f);

    // Accept beats load-use.
    load_use = 1'b1;
    irq      = 4'b0100;
    pc_id    = 32'h88;
    settle();
    check_val("acc_lu_rsts", 32'(rsts), 32'h08);
    check_val("acc_lu_ens", 32'(ens), 32'h0f);
    tick();
    load_use = 1'b0;
    irq      = '0;
    settle();
    check_val("acc_lu_cause", 32'(cause), 32'h2);
    check_val("acc_lu_epc", epc, 32'h88);

`ifdef DEBUG_STEP_EN
    // Freeze in DRAIN (counter 0), then single-step.
    debug_en = 1'b1;
    settle();
    check_val("dbg_ens", 32'(ens), 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("dbg_hold_state", 32'(dut.r_state), 32'h1);
      check_val("dbg_hold_cnt", 32'(dut.r_cnt), 32'h0);
    end
    debug_step = 1'b1;
    tick();
    check_val("dbg_step1", 32'(dut.r_cnt), 32'h1);
    tick();
    check_val("dbg_step_hi", 32'(dut.r_cnt), 32'h1);
    debug_step = 1'b0;
    tick();
    debug_step = 1'b1;
    tick();
    check_val("dbg_step2", 32'(dut.r_cnt), 32'h2);
    debug_step = 1'b0;
    debug_en   = 1'b0;
    // Counter at last drain value; next edge enters VECTOR, so reset one cycle
    // earlier-equivalent is not available here: restart entry instead.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_valid = 1'b1;
    irq      = 4'b0100;
    pc_id    = 32'h88;
    tick();
    irq = '0;
    settle();
`endif

    // Reset in the second DRAIN cycle aborts entry.
    tick();
    rst = 1'b1;
    settle();
    check_val("abort_rsts", 32'(rsts), 32'h1f);
    check_val("abort_redir", 32'(pc_redirect), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check_val("abort_state", 32'(dut.r_state), 32'h0);
    check_val("abort_isr", 32'(in_isr), 32'h0);
    check_val("abort_epc", epc, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check_val("abort_no_redir", 32'(pc_redirect), 32'h0);
      tick();
    end
    check_val("abort_isr_late", 32'(in_isr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
